// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding codes,
// FSM state encoding and stall-counter width.
package hazard_ctrl_pkg;

  localparam int STALL_CNT_W = 16;

  localparam logic [5:0] DEP_NONE        = 6'd0;
  localparam logic [5:0] DEP_ALU_EX      = 6'd1;
  localparam logic [5:0] DEP_ALU_MEM     = 6'd2;
  localparam logic [5:0] DEP_MEMRD_EX_RS = 6'd3;
  localparam logic [5:0] DEP_MEMRD_EX_RT = 6'd3;
  localparam logic [5:0] DEP_WB          = 6'd4;
  localparam logic [5:0] DEP_MEMRD_MEM   = 6'd5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DMISS  = 2'd1,
    IMISS  = 2'd2,
    HALTED = 2'd3
  } hz_state_e;

  // Only a load still in EX needs a bubble; every other code (including
  // out-of-range ones) is satisfied by forwarding.
  function automatic logic is_load_use(input logic [5:0] rs, input logic [5:0] rt);
    return (rs == DEP_MEMRD_EX_RS) || (rt == DEP_MEMRD_EX_RT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; increments one cycle after inc, sticks at all-ones.
// Synchronous active-high clear; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational stage enables from FSM state and
// hazard inputs; a suppressed mispredict is remembered until IF/ID next advances.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             dep_code_rs,
  input  logic [5:0]             dep_code_rt,
  input  logic                   mispredict_ID,
  input  logic                   imem_ready,
  input  logic                   dmem_req_MEM,
  input  logic                   dmem_ready,
  input  logic                   halt_WB,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   exmem_write,
  output logic                   memwb_write,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  hz_state_e state_q, state_d;
  logic      pending_q, pending_d;
  logic      freeze;
  logic      load_use;
  logic      d_miss;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    freeze      = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    halted      = 1'b0;
    load_use    = is_load_use(dep_code_rs, dep_code_rt);
    d_miss      = dmem_req_MEM && !dmem_ready;

    if (state_q == HALTED) begin
      freeze = 1'b1;
      halted = 1'b1;
    end else if (halt_WB) begin
      freeze  = 1'b1;
      state_d = HALTED;
    end else begin
      case (state_q)
        DMISS: begin
          if (!dmem_ready) begin
            freeze    = 1'b1;
            pending_d = pending_q | mispredict_ID;
          end else begin
            ifid_flush = pending_q | mispredict_ID;
            state_d    = RUN;
          end
        end
        IMISS: begin
          if (d_miss) begin
            freeze    = 1'b1;
            pending_d = pending_q | mispredict_ID;
            state_d   = DMISS;
          end else if (mispredict_ID) begin
            ifid_flush = 1'b1;
            state_d    = RUN;
          end else if (!imem_ready) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
          end else begin
            ifid_flush = pending_q;
            state_d    = RUN;
          end
        end
        default: begin
          if (d_miss) begin
            freeze    = 1'b1;
            pending_d = pending_q | mispredict_ID;
            state_d   = DMISS;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            pending_d   = pending_q | mispredict_ID;
          end else if (mispredict_ID) begin
            ifid_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            state_d    = IMISS;
          end else begin
            ifid_flush = pending_q;
          end
        end
      endcase
    end

    if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end

    // Any cycle IF/ID loads carries the owed flush with it.
    if (ifid_write) pending_d = 1'b0;

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (!reset && (state_q != HALTED) && !pc_write),
    .cnt  (stall_cycles)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-002 The block SHALL have these inputs:
- dep_code_rs  in  6  rs forwarding code from dependency detector (0..5).
- dep_code_rt  in  6  rt forwarding code (0..5).
- mispredict_ID  in  1  branch/jump resolved wrong in ID.
- imem_ready  in  1  I-cache has the fetch word this cycle.
- dmem_req_MEM  in  1  load/store in MEM this cycle.
- dmem_ready  in  1  D-cache completes the MEM access this cycle.
- halt_WB  in  1  valid HLT in WB.
REQ-003 The block SHALL have these outputs:
- pc_write  out  1
- ifid_write  out  1
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_write  out  1
- memwb_write  out  1
- halted  out  1
- stall_cycles  out  16  saturating count of non-advancing cycles.

Function
REQ-004 The FSM SHALL have states RUN, DMISS, IMISS, HALTED; output decode SHALL be combinational from state and inputs.
REQ-005 Load-use SHALL be detected when dep_code_rs==3 or dep_code_rt==3. It SHALL require exactly one stall cycle: pc_write=0, ifid_write=0, idex_bubble=1, others 1. The state SHALL remain RUN.
REQ-006 RUN with dmem_req_MEM=1 and dmem_ready=0 SHALL freeze all stages that cycle (pc_write, ifid_write, exmem_write, memwb_write=0; flush=bubble=0). The next state SHALL be DMISS.
REQ-007 DMISS SHALL hold the freeze while dmem_ready=0. On the dmem_ready=1 cycle all writes SHALL be 1 and the next state SHALL be RUN.
REQ-008 RUN with imem_ready=0 and no D-miss or load-use SHALL give pc_write=0, ifid_flush=1, others advancing. The next state SHALL be IMISS; IMISS SHALL repeat this until imem_ready=1, then return to RUN.
REQ-009 Mispredict_ID in RUN, with no higher-priority event, SHALL give ifid_flush=1 with pc_write=1.
REQ-010 Priority SHALL be halt > D-miss > load-use > mispredict > I-miss.
REQ-011 Mispredict_ID while a higher-priority event suppresses it SHALL set pending_flush.
REQ-012 pending_flush SHALL force ifid_flush=1 on the first cycle that IF/ID advances (ifid_write=1 or IMISS exit), then clear.
REQ-013 Mispredict in IMISS SHALL redirect immediately: pc_write=1, ifid_flush=1, next state RUN, no pending set.
REQ-014 halt_WB=1 in any state SHALL enter HALTED next cycle.
REQ-015 HALTED SHALL be sticky until reset. In HALTED all write enables, flush and bubble SHALL be 0 and halted=1.
REQ-016 stall_cycles SHALL increment by 1 on every non-HALTED cycle where pc_write=0, and SHALL saturate at 16'hFFFF.
REQ-017 dep codes other than 3 SHALL never cause a stall; codes 6..63 SHALL be treated as 0.

Reset
REQ-018 While reset=1, at each clock edge: state=RUN, pending_flush=0, stall_cycles=0.
REQ-019 While reset=1, the outputs SHALL be: all write enables 0, ifid_flush=0, idex_bubble=0, halted=0.
REQ-020 Reset mid-DMISS/IMISS/HALTED SHALL abandon that state with no residual pending_flush.

Structure
REQ-021 A shared header SHALL define: the DEP_* code values (DEP_MEMRD_EX_RS/RT=3), the 2-bit state encoding (RUN=0, DMISS=1, IMISS=2, HALTED=3), and STALL_CNT_W=16.
REQ-022 One sub-module, sat_counter, SHALL implement the parameterized saturating stall counter. The FSM and decode SHALL remain in hazard_ctrl.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- Load-use: dep_code_rt=3 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; stall_cycles 0->1.
- D-miss: dmem_req_MEM=1, dmem_ready=0 for 4 cycles then 1 -> 4 frozen cycles then all writes 1; state back to RUN; stall_cycles=4.
- Mispredict during D-miss at cycle 2 -> no flush while frozen; ifid_flush=1 on release cycle; pending cleared next cycle.
- I-miss of 3 cycles with mispredict_ID on its 2nd cycle -> immediate pc_write=1, ifid_flush=1, state RUN.
- halt_WB=1 during IMISS -> halted=1 from next cycle; later imem_ready/mispredict inputs are ignored; reset clears to RUN with stall_cycles=0.
- Saturation: preload via 65535 stall cycles, then 2 more -> stall_cycles stays 16'hFFFF.
